// File: rtl/sipo_deser_pkg.sv
// Project-wide constants for the decoded-bit deserializer.
package sipo_deser_pkg;

    // Default word width used when the deserializer is instantiated at top level
    localparam int BYTE_W = 8;

endpackage

// File: rtl/sipo_deser_skid.sv
// Output register of the deserializer: holds one word, its bit count and
// the valid flag until the downstream consumer takes it.
module sipo_deser_skid #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    input  logic [CNT_W-1:0]  load_cnt,
    input  logic              ready,
    output logic [DATA_W-1:0] word,
    output logic [CNT_W-1:0]  cnt,
    output logic              valid
);

    // Load a new word when offered; otherwise drop valid after a handshake
    // while leaving word/cnt untouched so they stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            word  <= load_word;
            cnt   <= load_cnt;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer for the decoded-bit path: packs bits into
// DATA_W-bit words with selectable bit order, supports flushing a partial
// word with a bit count, and uses the shift stage as a one-word skid buffer.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int DATA_W    = BYTE_W,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_i,
    input  logic              bit_valid_i,
    output logic              bit_ready_o,
    input  logic              flush_i,
    output logic [DATA_W-1:0] word_o,
    output logic [CNT_W-1:0]  word_cnt_o,
    output logic              word_valid_o,
    input  logic              word_ready_i
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    logic [DATA_W-1:0] shift_reg;
    logic [CNT_W-1:0]  count;
    logic              shift_full;

    logic              accept;
    logic              slot_free;
    logic              complete;
    logic              load;
    logic [DATA_W-1:0] placed;
    logic [DATA_W-1:0] next_reg;
    logic [DATA_W-1:0] aligned;
    logic [CNT_W-1:0]  cnt_acc;
    logic [DATA_W-1:0] load_word;
    logic [CNT_W-1:0]  load_cnt;

    assign bit_ready_o = !shift_full;
    assign accept      = bit_valid_i && !shift_full;
    assign slot_free   = !word_valid_o || word_ready_i;

    // Place the incoming bit, count it, detect word completion (full word or
    // flush of a non-empty word) and left-justify partial MSB-first words.
    always_comb begin
        placed = shift_reg;
        if (MSB_FIRST != 0) begin
            placed = {shift_reg[DATA_W-2:0], bit_i};
        end else begin
            placed = shift_reg | (DATA_W'(bit_i) << count);
        end
        next_reg = accept ? placed : shift_reg;
        cnt_acc  = count + CNT_W'(accept);
        complete = !shift_full &&
                   ((accept && (cnt_acc == FULL_CNT)) || (flush_i && (cnt_acc != '0)));
        aligned  = next_reg;
        if (MSB_FIRST != 0) begin
            aligned = next_reg << (FULL_CNT - cnt_acc);
        end
    end

    // A held word always drains first; otherwise a freshly completed word
    // goes straight to the output register when the slot is free.
    assign load      = slot_free && (shift_full || complete);
    assign load_word = shift_full ? shift_reg : aligned;
    assign load_cnt  = shift_full ? count : cnt_acc;

    // Shift stage: accumulate bits, clear on handoff, or hold a completed
    // word (already aligned) while the output slot is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            count      <= '0;
            shift_full <= 1'b0;
        end else if (shift_full) begin
            if (slot_free) begin
                shift_reg  <= '0;
                count      <= '0;
                shift_full <= 1'b0;
            end
        end else if (complete) begin
            if (slot_free) begin
                shift_reg <= '0;
                count     <= '0;
            end else begin
                shift_reg  <= aligned;
                count      <= cnt_acc;
                shift_full <= 1'b1;
            end
        end else if (accept) begin
            shift_reg <= next_reg;
            count     <= cnt_acc;
        end
    end

    sipo_deser_skid #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_word(load_word),
        .load_cnt (load_cnt),
        .ready    (word_ready_i),
        .word     (word_o),
        .cnt      (word_cnt_o),
        .valid    (word_valid_o)
    );

endmodule
